// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: registered N-channel WIDTH-bit selector with valid/ready handshakes.
//
// Picks one of NCH input channels, either by the `sel` port (mode=0) or by
// round-robin arbitration among valid channels (mode=1). The chosen word is
// captured in a single output register stage that has a valid/ready handshake.
//
// Parameters:
//   WIDTH  data width per channel
//   NCH    number of input channels (2..16)
//   SELW   width of sel / out_ch, 2**SELW >= NCH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, combinational, one-hot or zero
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   out_data   registered selected data
//   out_ch     registered source channel index
//   out_valid  output register holds data
//   out_ready  consumer accepts out_data this cycle
//   out_par    (only with MUXN_RR_REG_PARITY_EN) XOR of the registered data word
//
// Optional feature macro: MUXN_RR_REG_PARITY_EN adds the out_par port and its register.

module muxn_rr_reg #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned NCH   = 3,
    parameter int unsigned SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUXN_RR_REG_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    // Number of codes addressable by a SELW-bit index; valids are padded to this
    // so any index (including illegal ones >= NCH) is in range.
    localparam int unsigned NSel = 2 ** SELW;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [SELW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]  r_data;
    logic [SELW-1:0]   r_ch;

    logic [NSel-1:0]   w_valid_ext;
    logic              w_ld;
    logic              w_load;
    logic              w_fix_vld;
    logic              w_rr_vld;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_gnt_vld;
    logic [SELW-1:0]   w_gnt_idx;
    logic [WIDTH-1:0]  w_gnt_data;
    logic [SELW-1:0]   w_rr_ptr_next;

    // Channel index ptr+k wrapped modulo NCH; ptr is always < NCH.
    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] ptr,
                                               input int unsigned k);
        int unsigned s;
        s = 32'(ptr) + k;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return SELW'(s);
    endfunction

    assign w_valid_ext = NSel'(in_valid);

    // The output register can take a new word when empty or being drained.
    assign w_ld = (r_state == StEmpty) | out_ready;

    // Fixed select: an out-of-range sel never grants.
    assign w_fix_vld = (32'(sel) < NCH) & w_valid_ext[sel];

    // Round-robin: first valid channel starting at r_rr_ptr wins.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!w_rr_vld && w_valid_ext[rr_idx(r_rr_ptr, k)]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_gnt_vld = mode ? w_rr_vld : w_fix_vld;
    assign w_gnt_idx = mode ? w_rr_idx : sel;
    assign w_load    = w_ld & w_gnt_vld;

    always_comb begin
        w_gnt_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept is blocked while reset is asserted even though the FSM sits in EMPTY.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            in_ready[i] = rst_n & w_load & (w_gnt_idx == SELW'(i));
        end
    end

    assign w_rr_ptr_next = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);

    // Output FSM: next-state logic.
    always_comb begin
        w_state_next = r_state;
        if (w_ld) begin
            w_state_next = w_gnt_vld ? StFull : StEmpty;
        end
    end

    // Output FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data path registers; they hold their last value when the FSM drains to EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_data   <= w_gnt_data;
            r_ch     <= w_gnt_idx;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

`ifdef MUXN_RR_REG_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_gnt_data;
        end
    end

    assign out_par = r_par;
`endif

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = (r_state == StFull);

endmodule

// File: tb/tb_muxn_rr_reg.sv
module tb_muxn_rr_reg;

    logic        clk;
    logic        rst_n;
    logic [35:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [11:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
`ifdef MUXN_RR_REG_PARITY_EN
    logic        out_par;
`endif

    int checks;
    int failures;

    logic [11:0] vals [3];

    muxn_rr_reg #(
        .WIDTH (12),
        .NCH   (3),
        .SELW  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUXN_RR_REG_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        mode      = 1'b0;
        sel       = 2'd1;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 12'd0 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%0d ch=%0d expected v=0 d=0 ch=0",
                     out_valid, out_data, out_ch);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        mode      = 1'b0;
        sel       = 2'd1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            failures++;
            $display("FAIL fixed_in_ready: got %b expected 010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'd2142 || out_ch !== 2'd1) begin
            failures++;
            $display("FAIL fixed_out: got v=%b d=%0d ch=%0d expected v=1 d=2142 ch=1",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode      = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (in_ready !== (3'b001 << (i % 3))) begin
                failures++;
                $display("FAIL rr_in_ready[%0d]: got %b expected %b", i, in_ready,
                         3'b001 << (i % 3));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % 3) || out_data !== vals[i % 3]) begin
                failures++;
                $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%0d expected v=1 ch=%0d d=%0d",
                         i, out_valid, out_ch, out_data, i % 3, vals[i % 3]);
            end
        end
    endtask

    task automatic test_backpressure();
        // Pointer is at 0 after the round-robin sequence; load ch0 first.
        tick();
        checks++;
        if (out_ch !== 2'd0 || out_data !== 12'd254) begin
            failures++;
            $display("FAIL bp_load0: got ch=%0d d=%0d expected ch=0 d=254", out_ch, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 3'b000) begin
                failures++;
                $display("FAIL bp_in_ready[%0d]: got %b expected 000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'd254 || out_ch !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0d ch=%0d expected v=1 d=254 ch=0",
                         i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            failures++;
            $display("FAIL bp_release_ready: got %b expected 010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'd2142 || out_ch !== 2'd1) begin
            failures++;
            $display("FAIL bp_refill: got v=%b d=%0d ch=%0d expected v=1 d=2142 ch=1",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_illegal_sel();
        mode      = 1'b0;
        sel       = 2'd3;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++;
            $display("FAIL illegal_in_ready: got %b expected 000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 12'd2142 || out_ch !== 2'd1) begin
            failures++;
            $display("FAIL illegal_drain: got v=%b d=%0d ch=%0d expected v=0 d=2142 ch=1",
                     out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 3'b000) begin
            failures++;
            $display("FAIL illegal_empty_ready: got %b expected 000", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        mode      = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        sel       = 2'd2;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            failures++;
            $display("FAIL b2b_ready_sel2: got %b expected 100", in_ready);
        end
        tick();
        sel = 2'd0;
        #1;
        checks++;
        if (out_ch !== 2'd2 || out_data !== 12'd1565 || in_ready !== 3'b001) begin
            failures++;
            $display("FAIL b2b_sel2: got ch=%0d d=%0d rdy=%b expected ch=2 d=1565 rdy=001",
                     out_ch, out_data, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 12'd254) begin
            failures++;
            $display("FAIL b2b_sel0: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=254",
                     out_valid, out_ch, out_data);
        end
        // Selected channel not valid: no grant, output drains.
        in_valid = 3'b110;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            failures++;
            $display("FAIL b2b_invalid_ready: got %b expected 000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got v=%b expected v=0", out_valid);
        end
        // Fixed-mode grant of ch0 moved the pointer to 1; ch1 idle so ch2 wins.
        mode     = 1'b1;
        in_valid = 3'b101;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            failures++;
            $display("FAIL ptr_fixed_update: got %b expected 100", in_ready);
        end
        tick();
        #1;
        checks++;
        if (out_ch !== 2'd2 || in_ready !== 3'b001) begin
            failures++;
            $display("FAIL ptr_wrap_after2: got ch=%0d rdy=%b expected ch=2 rdy=001",
                     out_ch, in_ready);
        end
    endtask

    task automatic test_sparse_rr();
        do_reset();
        mode      = 1'b1;
        in_valid  = 3'b100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            failures++;
            $display("FAIL sparse_ready: got %b expected 100", in_ready);
        end
        tick();
        in_valid = 3'b011;
        #1;
        checks++;
        if (out_ch !== 2'd2 || out_data !== 12'd1565 || in_ready !== 3'b001) begin
            failures++;
            $display("FAIL sparse_wrap: got ch=%0d d=%0d rdy=%b expected ch=2 d=1565 rdy=001",
                     out_ch, out_data, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL sparse_load0: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
        end
        // Asynchronous reset in the middle of the cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 12'd0 || out_ch !== 2'd0 ||
            in_ready !== 3'b000) begin
            failures++;
            $display("FAIL async_reset: got v=%b d=%0d ch=%0d rdy=%b expected v=0 d=0 ch=0 rdy=000",
                     out_valid, out_data, out_ch, in_ready);
        end
        tick();
        rst_n = 1'b1;
    endtask

`ifdef MUXN_RR_REG_PARITY_EN
    task automatic test_parity();
        do_reset();
        checks++;
        if (out_par !== 1'b0) begin
            failures++;
            $display("FAIL parity_reset: got %b expected 0", out_par);
        end
        mode      = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        sel       = 2'd1;
        tick();
        checks++;
        if (out_par !== 1'b0) begin
            failures++;
            $display("FAIL parity_2142: got %b expected 0", out_par);
        end
        sel = 2'd0;
        tick();
        checks++;
        if (out_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_254: got %b expected 1", out_par);
        end
        out_ready = 1'b0;
        sel       = 2'd1;
        tick();
        checks++;
        if (out_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_hold: got %b expected 1", out_par);
        end
        out_ready = 1'b1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        vals[0]  = 12'd254;
        vals[1]  = 12'd2142;
        vals[2]  = 12'd1565;
        in_data  = {vals[2], vals[1], vals[0]};
        in_valid = 3'b000;
        mode     = 1'b0;
        sel      = 2'd0;
        out_ready = 1'b0;
        rst_n    = 1'b0;

        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_illegal_sel();
        test_back_to_back();
        test_sparse_rr();
`ifdef MUXN_RR_REG_PARITY_EN
        test_parity();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
